fft8_twiddle_mul: RTL and testbench
===================================

Name: fft8_twiddle_mul

Overview:
Twiddle-multiply stage between radix-2 SDF butterfly stages of the 8-point FFT.
- Consumes the butterfly output stream and counts samples within each 8-sample frame.
- Derives the twiddle index and drives the 8-entry Q10 twiddle ROM, instantiated internally with its output register enabled.
- Performs the complex multiply, rounds, rescales and emits the result with a valid strobe.
- Sits directly downstream of a butterfly and upstream of the next butterfly stage.

Parameters:
- WIDTH, 16: data width of each real/imag sample, two's complement.
- STAGE, 1: twiddle pattern. 1 = after the first DIF butterfly (W8^0..3). 2 = after the second DIF butterfly (W8^0, W8^2).

Ports:
- clk  in  1  master clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- din_en  in  1  input sample valid
- din_re  in  WIDTH  input sample, real
- din_im  in  WIDTH  input sample, imag
- dout_en  out  1  output sample valid
- dout_re  out  WIDTH  twiddled sample, real
- dout_im  out  WIDTH  twiddled sample, imag

Behaviour:
- Reset (asynchronous, active-low): cnt=0, all valid pipeline flags=0, dout_en=0, dout_re=0, dout_im=0. Data registers also clear to 0.
- cnt: 3-bit sample counter. Increments on each din_en; wraps 7->0; holds when din_en=0. Gaps in din_en are legal; no backpressure exists.
- Twiddle address from the cnt value of the accepted sample:
  - STAGE=1: addr = cnt[2] ? {1'b0,cnt[1:0]} : 0.
  - STAGE=2: addr = cnt[1] ? {cnt[0],2'b0}>>1 : 0, i.e. addr = 2 when cnt[1]&cnt[0], else 0.
  - Any other STAGE value: addr = 0.
- Pipeline (4 cycles din_en -> dout_en, fixed, independent of gaps):
  - C0: register din, addr, valid v0.
  - C1: ROM output register yields tw_re/tw_im for addr; data delayed one register to align; v1.
  - C2: four signed products registered, each WIDTH+18 bits: a*c, b*d, a*d, b*c, with a=din_re, b=din_im, c=tw_re, d=tw_im; v2.
  - C3: re = ac-bd, im = ad+bc at WIDTH+19 bits. Add 512, arithmetic shift right 10 (round half up). Limit to WIDTH (see optional feature). Register to dout; dout_en=v2.
- Every sample, including addr 0 (W=1024), passes through the multiplier. addr 0 result equals input exactly.
- dout_re/dout_im hold their last value while dout_en=0.
- Back-to-back din_en every cycle: one output per cycle, order preserved.
- Reset mid-frame: in-flight samples are discarded (valids cleared) and cnt returns to 0. The next accepted sample is frame index 0.
- The ROM has no reset; its contents are only consumed under a valid flag.

Optional Feature:
Macro FFT8_TWMUL_SAT_EN.
- Defined: the rounded result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Undefined: the rounded result is truncated to its low WIDTH bits (two's complement wrap).
- Latency is identical either way.

Test Plan:
- Reset then idle: dout_en=0, dout=(0,0). Assert rst_n low mid-stream -> dout_en drops asynchronously; next frame restarts at cnt 0.
- STAGE=1, WIDTH=16, 8 back-to-back samples (1000,0) -> dout_en high for 8 cycles starting 4 cycles after the first din_en, with outputs in order:
  - samples 0..4 -> (1000,0)
  - sample 5 -> (707,-708)
  - sample 6 -> (0,-1000)
  - sample 7 -> (-708,-708)
- STAGE=2, 8 samples (0,512) -> samples 0,1,2,4,5,6 -> (0,512); samples 3,7 (W8^2=(0,-1024)) -> (512,0).
- Gapped input: din_en every other cycle for 8 samples (1000,0), STAGE=1 -> same 8 outputs as the back-to-back case, each 4 cycles after its input, with gaps preserved.
- Saturation: STAGE=1, sample index 7 = (-32768,-32768), so ad+bc = 47513600:
  - with FFT8_TWMUL_SAT_EN -> (0,32767)
  - without -> (0,-19136)
- Wrap: 16 consecutive samples -> addr sequence 0,0,0,0,0,1,2,3 repeats for the second frame.

Source files
------------

// File: rtl/fft8_twiddle_mul.sv
// Twiddle-multiply stage between radix-2 SDF butterflies of an 8-point FFT.
// Build option FFT8_TWMUL_SAT_EN: saturate the rounded result instead of wrapping it.

module fft8_twiddle_rom (
    input  logic               clk,
    input  logic [2:0]         addr,
    output logic signed [17:0] tw_re,
    output logic signed [17:0] tw_im
);

    // Registered W8^k = exp(-j*2*pi*k/8) in Q10, each component floored
    always_ff @(posedge clk) begin
        case (addr)
            3'd0: begin tw_re <=  18'sd1024; tw_im <=  18'sd0;    end
            3'd1: begin tw_re <=  18'sd724;  tw_im <= -18'sd725;  end
            3'd2: begin tw_re <=  18'sd0;    tw_im <= -18'sd1024; end
            3'd3: begin tw_re <= -18'sd725;  tw_im <= -18'sd725;  end
            3'd4: begin tw_re <= -18'sd1024; tw_im <=  18'sd0;    end
            3'd5: begin tw_re <= -18'sd725;  tw_im <=  18'sd724;  end
            3'd6: begin tw_re <=  18'sd0;    tw_im <=  18'sd1024; end
            3'd7: begin tw_re <=  18'sd724;  tw_im <=  18'sd724;  end
            default: begin tw_re <= 18'sd1024; tw_im <= 18'sd0;   end
        endcase
    end

endmodule

module fft8_twiddle_mul #(
    parameter int WIDTH = 16,
    parameter int STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_en,
    input  logic [WIDTH-1:0] din_re,
    input  logic [WIDTH-1:0] din_im,
    output logic             dout_en,
    output logic [WIDTH-1:0] dout_re,
    output logic [WIDTH-1:0] dout_im
);

    localparam int TW_W = 18;
    localparam int PW   = WIDTH + TW_W;
    localparam int SW   = PW + 1;
    localparam logic signed [SW-1:0] RND = {{(SW-10){1'b0}}, 10'd512};
`ifdef FFT8_TWMUL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [2:0]              cnt_r;
    logic [2:0]              addr_s;
    logic [2:0]              addr_r;
    logic                    v0_r, v1_r, v2_r;
    logic signed [WIDTH-1:0] d0_re_r, d0_im_r, d1_re_r, d1_im_r;
    logic signed [TW_W-1:0]  tw_re_s, tw_im_s;
    logic signed [PW-1:0]    p_ac_r, p_bd_r, p_ad_r, p_bc_r;
    logic signed [SW-1:0]    sum_re_s, sum_im_s, rnd_re_s, rnd_im_s;
    logic [WIDTH-1:0]        lim_re_s, lim_im_s;

    function automatic logic [WIDTH-1:0] limit_sat(input logic signed [SW-1:0] v);
        logic [SW-WIDTH:0] top;
        top = v[SW-1:WIDTH-1];
        if ((&top) || !(|top)) begin
            limit_sat = v[WIDTH-1:0];
        end else if (v[SW-1]) begin
            limit_sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            limit_sat = {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    // Twiddle address from the frame position of the sample being accepted
    always_comb begin
        addr_s = 3'd0;
        if (STAGE == 1) begin
            if (cnt_r[2]) addr_s = {1'b0, cnt_r[1:0]};
            else          addr_s = 3'd0;
        end else if (STAGE == 2) begin
            if (cnt_r[1] && cnt_r[0]) addr_s = 3'd2;
            else                      addr_s = 3'd0;
        end else begin
            addr_s = 3'd0;
        end
    end

    // C0: frame counter, input capture and address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 3'd0;
            addr_r  <= 3'd0;
            v0_r    <= 1'b0;
            d0_re_r <= '0;
            d0_im_r <= '0;
        end else begin
            v0_r <= din_en;
            if (din_en) begin
                cnt_r   <= cnt_r + 3'd1;
                addr_r  <= addr_s;
                d0_re_r <= din_re;
                d0_im_r <= din_im;
            end
        end
    end

    fft8_twiddle_rom u_rom (
        .clk   (clk),
        .addr  (addr_r),
        .tw_re (tw_re_s),
        .tw_im (tw_im_s)
    );

    // C1/C2: align data with the ROM output, then form the four partial products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            d1_re_r <= '0;
            d1_im_r <= '0;
            p_ac_r  <= '0;
            p_bd_r  <= '0;
            p_ad_r  <= '0;
            p_bc_r  <= '0;
        end else begin
            v1_r    <= v0_r;
            v2_r    <= v1_r;
            d1_re_r <= d0_re_r;
            d1_im_r <= d0_im_r;
            p_ac_r  <= PW'(d1_re_r) * PW'(tw_re_s);
            p_bd_r  <= PW'(d1_im_r) * PW'(tw_im_s);
            p_ad_r  <= PW'(d1_re_r) * PW'(tw_im_s);
            p_bc_r  <= PW'(d1_im_r) * PW'(tw_re_s);
        end
    end

    // C3 datapath: combine, round half up, drop the Q10 scale, limit to WIDTH
    always_comb begin
        sum_re_s = SW'(p_ac_r) - SW'(p_bd_r);
        sum_im_s = SW'(p_ad_r) + SW'(p_bc_r);
        rnd_re_s = (sum_re_s + RND) >>> 4'd10;
        rnd_im_s = (sum_im_s + RND) >>> 4'd10;
        if (SAT_EN) begin
            lim_re_s = limit_sat(rnd_re_s);
            lim_im_s = limit_sat(rnd_im_s);
        end else begin
            lim_re_s = rnd_re_s[WIDTH-1:0];
            lim_im_s = rnd_im_s[WIDTH-1:0];
        end
    end

    // C3: output register; data holds between valid samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_en <= 1'b0;
            dout_re <= '0;
            dout_im <= '0;
        end else begin
            dout_en <= v2_r;
            if (v2_r) begin
                dout_re <= lim_re_s;
                dout_im <= lim_im_s;
            end
        end
    end

endmodule

// File: tb/tb_fft8_twiddle_mul.sv
// Directed bench for fft8_twiddle_mul: STAGE=1 and STAGE=2 instances share one input stream.

module tb_fft8_twiddle_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_en = 1'b0;
    logic [15:0] din_re = 16'd0;
    logic [15:0] din_im = 16'd0;
    logic        u1_en, u2_en;
    logic [15:0] u1_re, u1_im, u2_re, u2_im;

    int vectors = 0;
    int miscompares = 0;

    int e1_re[8]  = '{1000, 1000, 1000, 1000, 1000, 707, 0, -708};
    int e1_im[8]  = '{0, 0, 0, 0, 0, -708, -1000, -708};
    int e1w_re[8] = '{0, 0, 0, 0, 0, 363, 512, 363};
    int e1w_im[8] = '{512, 512, 512, 512, 512, 362, 0, -362};
`ifdef FFT8_TWMUL_SAT_EN
    int sat_im = 32767;
`else
    int sat_im = -19136;
`endif

    fft8_twiddle_mul #(.WIDTH(16), .STAGE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .din_en(din_en), .din_re(din_re), .din_im(din_im),
        .dout_en(u1_en), .dout_re(u1_re), .dout_im(u1_im)
    );

    fft8_twiddle_mul #(.WIDTH(16), .STAGE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .din_en(din_en), .din_re(din_re), .din_im(din_im),
        .dout_en(u2_en), .dout_re(u2_re), .dout_im(u2_im)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic e_en, input int e_re, input int e_im);
        chk({tag, "_en1"}, {31'd0, u1_en}, {31'd0, e_en});
        if (e_en) begin
            chk({tag, "_re1"}, $signed(u1_re), e_re);
            chk({tag, "_im1"}, $signed(u1_im), e_im);
        end
    endtask

    task automatic chk2(input string tag, input logic e_en, input int e_re, input int e_im);
        chk({tag, "_en2"}, {31'd0, u2_en}, {31'd0, e_en});
        if (e_en) begin
            chk({tag, "_re2"}, $signed(u2_re), e_re);
            chk({tag, "_im2"}, $signed(u2_im), e_im);
        end
    endtask

    initial begin
        // reset and idle
        repeat (2) tick();
        chk("rst_en", {31'd0, u1_en}, 32'sd0);
        chk("rst_re", $signed(u1_re), 32'sd0);
        chk("rst_im", $signed(u1_im), 32'sd0);
        chk("rst_en2", {31'd0, u2_en}, 32'sd0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk1("idle", 1'b0, 0, 0);

        // STAGE=1 back-to-back frame of (1000,0)
        for (int c = 0; c < 12; c++) begin
            din_en = (c < 8);
            din_re = 16'd1000;
            din_im = 16'd0;
            tick();
            if (c >= 3 && c < 11) chk1("b2b", 1'b1, e1_re[c-3], e1_im[c-3]);
            else                  chk1("b2b", 1'b0, 0, 0);
        end

        // second frame of (0,512): STAGE=2 pattern and STAGE=1 wrap
        for (int c = 0; c < 12; c++) begin
            din_en = (c < 8);
            din_re = 16'd0;
            din_im = 16'd512;
            tick();
            if (c >= 3 && c < 11) begin
                chk1("wrap", 1'b1, e1w_re[c-3], e1w_im[c-3]);
                if (c - 3 == 3 || c - 3 == 7) chk2("st2", 1'b1, 512, 0);
                else                          chk2("st2", 1'b1, 0, 512);
            end else begin
                chk2("st2", 1'b0, 0, 0);
            end
        end

        // gapped input, junk data while idle
        for (int c = 0; c < 20; c++) begin
            din_en = (c % 2 == 0) && (c < 16);
            din_re = din_en ? 16'd1000 : 16'h1234;
            din_im = din_en ? 16'd0 : 16'h4321;
            tick();
            if (c >= 3 && (c - 3) % 2 == 0 && (c - 3) / 2 < 8)
                chk1("gap", 1'b1, e1_re[(c-3)/2], e1_im[(c-3)/2]);
            else
                chk1("gap", 1'b0, 0, 0);
        end

        // overflow on sample 7 (W8^3)
        for (int c = 0; c < 12; c++) begin
            din_en = (c < 8);
            din_re = (c == 7) ? 16'h8000 : 16'd0;
            din_im = (c == 7) ? 16'h8000 : 16'd0;
            tick();
            if (c >= 3 && c < 11) chk1("sat", 1'b1, 0, (c == 10) ? sat_im : 0);
            else                  chk1("sat", 1'b0, 0, 0);
        end

        // reset mid-frame
        for (int c = 0; c < 5; c++) begin
            din_en = 1'b1;
            din_re = 16'd1000;
            din_im = 16'd0;
            tick();
        end
        chk1("pre_rst", 1'b1, 1000, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_en", {31'd0, u1_en}, 32'sd0);
        chk("arst_re", $signed(u1_re), 32'sd0);
        din_en = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            din_en = (c < 8);
            din_re = 16'd1000;
            din_im = 16'd0;
            tick();
            if (c >= 3 && c < 11) chk1("post_rst", 1'b1, e1_re[c-3], e1_im[c-3]);
            else                  chk1("post_rst", 1'b0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
